uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between NUM_REQ byte-stream requesters, e.g. debug console, CPU mailbox and status reporter.
- Grants are round-robin and packet-atomic: a granted requester holds the transmitter until its last byte is accepted.
- Optionally emits a channel-ID header byte before each packet.
- A watchdog releases the grant from a requester that stalls mid-packet.
- Sits directly in front of uart_transmitter: drives its have_new_data/new_data and observes its ready_for_new_data.

Parameters:
- NUM_REQ, 3, number of requesters (2..16).
- HEADER_EN, 1, 1 = send header byte {4'hA, id[3:0]} before each packet.
- TIMEOUT_CYCLES, 65535, mid-packet stall limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at [8*i+:8].
- req_last  in  NUM_REQ  byte is final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted this cycle when valid&ready.
- tx_ready  in  1  from transmitter ready_for_new_data.
- tx_valid  out  1  to transmitter have_new_data.
- tx_data  out  8  to transmitter new_data.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  state != IDLE.
- timeout_pulse  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Transfer to transmitter: tx_valid && tx_ready in the same cycle. Transfer from requester i: req_valid[i] && req_ready[i].
- Reset (async assert, sync deassert):
  - state=IDLE, grant=0, tx_valid=0, tx_data=0, req_ready=0, timeout_pulse=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-packet drops the packet; a byte already inside the transmitter finishes on its own.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid is high, select the first set bit searching from pointer+1 with wrap-around.
  - Register the selection into grant. Go to HEADER if HEADER_EN, else DATA. Arbitration takes 1 cycle.
- HEADER:
  - tx_valid=1, tx_data={4'hA, id}, req_ready=0.
  - On transfer, go to DATA.
  - Requester valid may drop during HEADER without effect.
- DATA (combinational pass-through, 0-cycle latency):
  - tx_valid = req_valid[g], tx_data = req_data[g], req_ready[g] = tx_ready.
  - All other req_ready bits stay 0.
  - On a transfer with req_last[g]=1: go to IDLE, grant=0, pointer=g.
- tx_data is 0 whenever tx_valid=0.
- Watchdog:
  - A 16-bit counter, active in DATA only, increments each cycle req_valid[g]=0.
  - It clears on every requester transfer and on leaving DATA.
  - When the counter reaches TIMEOUT_CYCLES-1 with valid still low: pulse timeout_pulse, go to IDLE, set pointer=g.
  - No byte is emitted for the aborted packet.
  - Stall while valid=1 and tx_ready=0 (transmitter busy) never counts.
- Simultaneous events:
  - New requests arriving during a packet wait; grant never changes mid-packet except on timeout.
  - A last-byte transfer and a timeout in the same cycle cannot occur, because the counter clears on the transfer.
- Fairness: back-to-back packets from all requesters are served 0,1,2,0,...; a requester is never granted twice while another is waiting.
- Single-byte packet (req_last on the first byte) is legal.
- IDLE→grant needs no tx_ready. HEADER/DATA simply hold while tx_ready=0; the transmitter deasserts ready for about 10 bit times per byte.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, HEADER, DATA);
  - HeaderMagic = 4'hA;
  - the header-byte build function.
- One sub-module: uart_rr_picker, a combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot pick and binary index.

Test Plan:
- NUM_REQ=3, HEADER_EN=1; req0 sends 2-byte packet 0x11,0x22(last) → transmitter receives 0xA0, 0x11, 0x22; grant=001 until the 0x22 transfer, then 0 and busy=0.
- req0 and req2 both assert valid in the same IDLE cycle after reset → req0 served first (header 0xA0), then req2 (header 0xA2); req2 bytes are never interleaved with req0 bytes.
- All three requesters continuously send 1-byte packets 0x55 → header sequence 0xA0,0xA1,0xA2,0xA0,...; each requester gets exactly 1 of every 3 packets.
- TIMEOUT_CYCLES=8; req1 sends 0x33 (not last), then drops valid → timeout_pulse high for exactly 1 cycle, 8 cycles after the 0x33 transfer; grant=0; next arbitration starts from req2.
- HEADER_EN=0; hold tx_ready=0 for 100 cycles with req0 valid, data 0x7E → tx_valid=1 and tx_data=0x7E stable, req_ready[0]=1 only in the cycle tx_ready rises, no timeout.
- Assert rst_n=0 mid-packet for 1 cycle → all outputs return to reset values asynchronously; after release, req0 with pending valid is granted again with a fresh header 0xA0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, DATA} arb_state_e;

  localparam logic [3:0] HeaderMagic = 4'hA;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HeaderMagic, id};
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin selector: first set request after ptr_i, with wrap.
module uart_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding one uart_transmitter, with optional
// channel-ID header and a mid-packet stall watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int HEADER_EN      = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      ptr_q;
  logic [15:0]        wd_q;
  logic               timeout_pulse_q;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               g_valid, g_last, g_xfer, wd_fire;
  logic [7:0]         g_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];
  assign g_data  = req_data[{gidx_q, 3'b000} +: 8];
  assign g_xfer  = (state_q == DATA) && g_valid && tx_ready;
  // Only an idle requester counts toward the stall limit; a busy transmitter never does.
  assign wd_fire = WD_EN && (state_q == DATA) && !g_valid && (wd_q == WD_LIMIT);

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state_q)
      HEADER: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(4'(gidx_q));
      end
      DATA: begin
        tx_valid          = g_valid;
        tx_data           = g_valid ? g_data : 8'h00;
        req_ready[gidx_q] = tx_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      gidx_q          <= '0;
      ptr_q           <= IW'(NUM_REQ - 1);
      wd_q            <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (|req_valid) begin
            grant_q <= pick;
            gidx_q  <= pick_idx;
            state_q <= (HEADER_EN != 0) ? HEADER : DATA;
          end
        end
        HEADER: if (tx_ready) state_q <= DATA;
        DATA: begin
          if (g_xfer) begin
            wd_q <= '0;
            if (g_last) begin
              state_q <= IDLE;
              grant_q <= '0;
              ptr_q   <= gidx_q;
            end
          end else if (wd_fire) begin
            timeout_pulse_q <= 1'b1;
            state_q         <= IDLE;
            grant_q         <= '0;
            ptr_q           <= gidx_q;
            wd_q            <= '0;
          end else if (WD_EN && !g_valid) begin
            wd_q <= wd_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: header/data ordering, round-robin, watchdog,
// transmitter back-pressure (no-header instance) and mid-packet reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_last, req_ready, grant;
  logic [23:0] req_data;
  logic        tx_ready, tx_valid, busy, timeout_pulse;
  logic [7:0]  tx_data;

  logic [2:0]  b_req_valid, b_req_last, b_req_ready, b_grant;
  logic [23:0] b_req_data;
  logic        b_tx_ready, b_tx_valid, b_busy, b_timeout_pulse;
  logic [7:0]  b_tx_data;

  int tests = 0, fails = 0;

  logic [8:0] rbuf [3][16];
  int         rhead [3];
  int         rtail [3];
  logic       txr;
  logic [7:0] tlog [64];
  logic [2:0] glog [64];
  int         tcyc [64];
  int         tn, cyc, pulses, pcyc;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(3), .HEADER_EN(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .grant(grant), .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .HEADER_EN(0), .TIMEOUT_CYCLES(8)) dut_nh (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_last(b_req_last), .req_ready(b_req_ready), .tx_ready(b_tx_ready),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .grant(b_grant), .busy(b_busy),
    .timeout_pulse(b_timeout_pulse)
  );

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (rhead[i] < rtail[i]) begin
        req_valid[i]      = 1'b1;
        req_last[i]       = rbuf[i][rhead[i]][8];
        req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
      end else begin
        req_valid[i]      = 1'b0;
        req_last[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
    tx_ready = txr;
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    if (rtail[i] < 16) begin
      rbuf[i][rtail[i]] = {last, d};
      rtail[i]++;
    end
  endtask

  // One clock: sample handshakes before the edge, log them after, advance requesters.
  task automatic tick();
    logic [2:0] acc;
    logic       fire;
    logic [7:0] d;
    logic [2:0] g;
    @(negedge clk);
    acc  = req_valid & req_ready;
    fire = tx_valid & tx_ready;
    d    = tx_data;
    g    = grant;
    @(posedge clk);
    #1;
    cyc++;
    if (fire && tn < 64) begin
      tlog[tn] = d; glog[tn] = g; tcyc[tn] = cyc; tn++;
    end
    for (int i = 0; i < 3; i++) if (acc[i]) rhead[i]++;
    if (timeout_pulse) begin pulses++; pcyc = cyc; end
    drive();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin rhead[i] = 0; rtail[i] = 0; end
    tn = 0; pulses = 0; pcyc = -1; cyc = 0; txr = 1'b1;
    drive();
    b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_tx_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 3'b111; req_last = 3'b111; req_data = 24'hFFFFFF; tx_ready = 1'b1;
    b_req_valid = 3'b111; b_req_last = '0; b_req_data = '0; b_tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (grant !== 3'b000 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        req_ready !== 3'b000 || timeout_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got g=%b busy=%b v=%b d=%h rdy=%b to=%b exp all zero",
               grant, busy, tx_valid, tx_data, req_ready, timeout_pulse);
    end
    tests++;
    if (b_grant !== 3'b000 || b_busy !== 1'b0 || b_tx_valid !== 1'b0 || b_req_ready !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs_nh got g=%b busy=%b v=%b rdy=%b exp all zero",
               b_grant, b_busy, b_tx_valid, b_req_ready);
    end
  endtask

  task automatic test_single_pkt();
    logic [7:0] e [3];
    e = '{8'hA0, 8'h11, 8'h22};
    do_reset();
    push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22);
    drive();
    tick();
    tests++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      fails++; $display("FAIL single_grant got g=%b busy=%b exp 001/1", grant, busy);
    end
    run(7);
    tests++;
    if (tn !== 3) begin fails++; $display("FAIL single_count got %0d exp 3", tn); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (tlog[k] !== e[k] || glog[k] !== 3'b001) begin
        fails++;
        $display("FAIL single_byte%0d got %h/g=%b exp %h/g=001", k, tlog[k], glog[k], e[k]);
      end
    end
    tests++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      fails++; $display("FAIL single_idle got g=%b busy=%b exp 000/0", grant, busy);
    end
  endtask

  task automatic test_two_req();
    logic [7:0] e [5];
    logic [2:0] eg [5];
    e  = '{8'hA0, 8'h10, 8'h12, 8'hA2, 8'h20};
    eg = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
    do_reset();
    push(0, 1'b0, 8'h10); push(0, 1'b1, 8'h12); push(2, 1'b1, 8'h20);
    drive();
    run(12);
    tests++;
    if (tn !== 5) begin fails++; $display("FAIL two_req_count got %0d exp 5", tn); end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (tlog[k] !== e[k] || glog[k] !== eg[k]) begin
        fails++;
        $display("FAIL two_req_byte%0d got %h/g=%b exp %h/g=%b", k, tlog[k], glog[k], e[k], eg[k]);
      end
    end
  endtask

  task automatic test_back_to_back_rr();
    int bad, cnt [3];
    logic [7:0] eh;
    do_reset();
    for (int p = 0; p < 3; p++) for (int i = 0; i < 3; i++) push(i, 1'b1, 8'h55);
    drive();
    run(35);
    tests++;
    if (tn !== 18) begin fails++; $display("FAIL rr_count got %0d exp 18", tn); end
    bad = 0;
    cnt = '{0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      eh = 8'(8'hA0 + k % 3);
      if (tlog[2*k] !== eh || tlog[2*k+1] !== 8'h55) begin
        bad++;
        $display("FAIL rr_pkt%0d got %h,%h exp %h,55", k, tlog[2*k], tlog[2*k+1], eh);
      end
      for (int i = 0; i < 3; i++) if (glog[2*k][i]) cnt[i]++;
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
      fails++;
      $display("FAIL rr_share got %0d/%0d/%0d exp 3/3/3", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    push(1, 1'b0, 8'h33);
    drive();
    run(15);
    tests++;
    if (tn !== 2 || tlog[0] !== 8'hA1 || tlog[1] !== 8'h33) begin
      fails++; $display("FAIL timeout_bytes got n=%0d %h,%h exp 2 A1,33", tn, tlog[0], tlog[1]);
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("FAIL timeout_pulse_width got %0d exp 1", pulses); end
    tests++;
    if (pcyc - tcyc[1] !== 8) begin
      fails++; $display("FAIL timeout_delay got %0d exp 8", pcyc - tcyc[1]);
    end
    tests++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_release got g=%b busy=%b exp 000/0", grant, busy);
    end
    push(0, 1'b1, 8'h60); push(2, 1'b1, 8'h62);
    drive();
    run(10);
    tests++;
    if (tn !== 6 || tlog[2] !== 8'hA2 || tlog[3] !== 8'h62 || tlog[4] !== 8'hA0 || tlog[5] !== 8'h60) begin
      fails++;
      $display("FAIL timeout_next_rr got n=%0d %h,%h,%h,%h exp 6 A2,62,A0,60",
               tn, tlog[2], tlog[3], tlog[4], tlog[5]);
    end
  endtask

  task automatic test_stall_no_header();
    int bad;
    do_reset();
    b_req_valid = 3'b001; b_req_data = 24'h00007E; b_req_last = 3'b001; b_tx_ready = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (b_grant !== 3'b001 || b_tx_valid !== 1'b1 || b_tx_data !== 8'h7E) begin
      fails++;
      $display("FAIL stall_grant got g=%b v=%b d=%h exp 001/1/7E", b_grant, b_tx_valid, b_tx_data);
    end
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (b_tx_valid !== 1'b1 || b_tx_data !== 8'h7E || b_req_ready !== 3'b000 ||
          b_timeout_pulse !== 1'b0 || b_grant !== 3'b001) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_hold got %0d bad cycles exp 0", bad); end
    b_tx_ready = 1'b1;
    #1;
    tests++;
    if (b_req_ready !== 3'b001) begin
      fails++; $display("FAIL stall_ready got %b exp 001", b_req_ready);
    end
    @(posedge clk);
    #1;
    b_tx_ready = 1'b0; b_req_valid = '0; b_req_last = '0;
    tests++;
    if (b_grant !== 3'b000 || b_busy !== 1'b0) begin
      fails++; $display("FAIL stall_done got g=%b busy=%b exp 000/0", b_grant, b_busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push(0, 1'b0, 8'h41); push(0, 1'b0, 8'h42); push(0, 1'b1, 8'h43);
    drive();
    run(3);
    tests++;
    if (tn !== 2 || busy !== 1'b1 || grant !== 3'b001) begin
      fails++; $display("FAIL midrst_pre got n=%0d busy=%b g=%b exp 2/1/001", tn, busy, grant);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (grant !== 3'b000 || busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        req_ready !== 3'b000 || timeout_pulse !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async got g=%b busy=%b v=%b d=%h rdy=%b exp all zero",
               grant, busy, tx_valid, tx_data, req_ready);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tn = 0;
    run(8);
    tests++;
    if (tn !== 3 || tlog[0] !== 8'hA0 || tlog[1] !== 8'h42 || tlog[2] !== 8'h43 || glog[0] !== 3'b001) begin
      fails++;
      $display("FAIL midrst_regrant got n=%0d %h,%h,%h g=%b exp 3 A0,42,43 g=001",
               tn, tlog[0], tlog[1], tlog[2], glog[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_two_req();
    test_back_to_back_rr();
    test_timeout();
    test_stall_no_header();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
